pong_game_ctrl: RTL

Game sequencer for the 2-player pong design. Owns match state (idle, serve, play, point, game over), both scores and the serve direction. Gates ball/paddle motion in the pixel-generation datapath. Sits beside Pixel_Generation: consumes refr_tick (one pulse per 60 Hz frame) and ball-miss pulses, drives enables and scores back into the datapath and score display.

---
 rtl/pong_pkg.sv | 15 +
 rtl/frame_timer.sv | 18 +
 rtl/pong_game_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, serve directions and default frame counts.
package pong_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;
  localparam logic SERVE_DIR_P1 = 1'b0;
  localparam logic SERVE_DIR_P2 = 1'b1;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int POINT_FRAMES_DEF = 90;
  localparam int OVER_FRAMES_DEF  = 300;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable frame down-counter; expire fires on the tick that consumes the last frame.
module frame_timer #(
  parameter int FRM_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [FRM_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);
  logic [FRM_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - 1'b1;
  assign expire = tick && cnt == FRM_W'(1);
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong match sequencer (states, scores, serve direction, motion enables).
// Optional PONG_AUTO_RESTART_EN: OVER returns to IDLE after OVER_FRAMES with scores cleared.
module pong_game_ctrl import pong_pkg::*; #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int POINT_FRAMES = POINT_FRAMES_DEF,
  parameter int OVER_FRAMES  = OVER_FRAMES_DEF,
  parameter int FRM_W        = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               refr_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_en,
  output logic               ball_rst,
  output logic               paddle_en,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  state_t cur, nxt;
  logic start_q, start_rise, expire, auto_exit, load;
  logic [FRM_W-1:0] load_val;
  assign start_rise = start & ~start_q;
  assign load = nxt != cur;
  assign load_val = nxt == SERVE ? FRM_W'(SERVE_FRAMES) :
                    nxt == POINT ? FRM_W'(POINT_FRAMES) : FRM_W'(OVER_FRAMES);
`ifdef PONG_AUTO_RESTART_EN
  assign auto_exit = expire;
`else
  assign auto_exit = 1'b0;
`endif
  frame_timer #(.FRM_W(FRM_W)) u_timer (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .tick(refr_tick), .expire(expire)
  );
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    nxt = start_rise ? SERVE : IDLE;
      SERVE:   nxt = expire ? PLAY : SERVE;
      PLAY:    nxt = (miss_left | miss_right) ? POINT : PLAY;
      POINT:   nxt = !expire ? POINT : (score1 == WIN || score2 == WIN) ? OVER : SERVE;
      OVER:    nxt = (start_rise | auto_exit) ? IDLE : OVER;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur       <= IDLE;
      start_q   <= 1'b0;
      score1    <= '0;
      score2    <= '0;
      serve_dir <= SERVE_DIR_P1;
      winner    <= 1'b0;
      ball_rst  <= 1'b0;
    end else begin
      cur      <= nxt;
      start_q  <= start;
      ball_rst <= nxt == SERVE && cur != SERVE;
      if ((cur == IDLE && start_rise) || (cur == OVER && auto_exit)) begin
        score1 <= '0;
        score2 <= '0;
      end else if (cur == PLAY && (miss_left ^ miss_right)) begin
        // the missing side's opponent scores and receives the next serve
        if (miss_right) begin
          score1    <= score1 + SCORE_W'(score1 != '1);
          serve_dir <= SERVE_DIR_P2;
        end else begin
          score2    <= score2 + SCORE_W'(score2 != '1);
          serve_dir <= SERVE_DIR_P1;
        end
      end
      if (cur == POINT && nxt == OVER) winner <= score2 == WIN;
    end
  end
  assign ball_en   = cur == PLAY;
  assign paddle_en = cur == SERVE || cur == PLAY;
  assign game_over = cur == OVER;
  assign state     = cur;
endmodule
